// File: rtl/posit_decode_pipe.sv
// ---------------------------------------------------------------------------
// posit_decode_pipe
//   Three-stage elastic pipeline that splits an N-bit posit word into its
//   sign, zero/NaR flags, signed regime value k, exponent field and fraction
//   field. The fraction does not include the hidden bit. It is MSB-aligned,
//   and any bits not present in the word are filled with zeros at the LSB end.
//
//   Stage 1 : sign, zero/NaR detect, two's-complement magnitude
//   Stage 2 : regime run length by leading-one detection
//   Stage 3 : shift out the regime, extract exp/frac, register the outputs
//
//   Each stage loads when it is empty or when the stage after it moves on.
//   The ready chain is combinational, so the pipeline sustains one word per
//   cycle. A full pipeline accepts a push in the same cycle as a pop.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   in_valid   : in_posit holds a word
//   in_ready   : the word is accepted this cycle (transfer = valid && ready)
//   in_posit   : raw posit word [N-1:0]
//   out_valid  : decoded result available
//   out_ready  : downstream takes the result this cycle
//   out_sign   : posit sign bit (0 for zero, 1 for NaR)
//   out_zero   : input was all zeros
//   out_nar    : input was NaR (1 followed by N-1 zeros)
//   out_k      : signed regime value [RS:0]
//   out_exp    : exponent field [ES-1:0]
//   out_frac   : fraction field [N-ES-4:0]
// ---------------------------------------------------------------------------
module posit_decode_pipe #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic signed [RS:0]   out_k,
  output logic [ES-1:0]        out_exp,
  output logic [N-ES-4:0]      out_frac
);

  localparam int FW  = N - ES - 3;   // fraction width
  localparam int FLD = N - 1;        // width of the field below the sign bit
  localparam int TW  = ES + FW;      // bits left once the two-bit minimum regime is gone

  // Leading-zero count over the conditioned regime field. An all-zero field
  // means the regime runs to the end of the word, so the count saturates at
  // FLD.
  function automatic logic [RS-1:0] lead_zero_count(input logic [FLD-1:0] v);
    logic [RS-1:0] cnt;
    logic          found;
    cnt   = RS'(FLD);
    found = 1'b0;
    for (int i = FLD - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        cnt   = RS'(FLD - 1 - i);
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  // -------------------------------------------------------------------------
  // Handshake chain
  // -------------------------------------------------------------------------
  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;

  assign s3_ready  = !s3_valid || out_ready;
  assign s2_ready  = !s2_valid || s3_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = !rst && s1_ready;
  assign out_valid = s3_valid;

  logic s1_load, s2_load, s3_load;
  assign s1_load = in_valid && in_ready;
  assign s2_load = s1_valid && s2_ready;
  assign s3_load = s2_valid && s3_ready;

  // -------------------------------------------------------------------------
  // Stage 1: sign, special-value detect, magnitude
  // -------------------------------------------------------------------------
  logic           s1_sign, s1_zero, s1_nar;
  logic [FLD-1:0] s1_field;
  logic [FLD-1:0] in_field;
  logic           in_low_zero;

  // The low N-1 bits of the two's complement of the whole word equal the
  // two's complement of the low N-1 bits. The magnitude sign bit is never
  // used, so only the low N-1 bits are formed.
  assign in_field    = in_posit[N-1] ? (~in_posit[FLD-1:0] + 1'b1) : in_posit[FLD-1:0];
  assign in_low_zero = (in_posit[FLD-1:0] == '0);

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= s1_load;
    end
  end

  // NOTE: the intermediate stage data registers are not reset. They are only
  // read when the matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sign  <= in_posit[N-1];
      s1_zero  <= !in_posit[N-1] && in_low_zero;
      s1_nar   <= in_posit[N-1] && in_low_zero;
      s1_field <= in_field;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: regime run length
  // -------------------------------------------------------------------------
  logic           s2_sign, s2_zero, s2_nar, s2_lead;
  logic [RS-1:0]  s2_r;
  logic [TW-1:0]  s2_tail;
  logic [FLD-1:0] cond_field;
  logic [RS-1:0]  run_len;

  // The field is inverted when it starts with a 1, so the run always becomes
  // a run of zeros. The top bit of the conditioned field is therefore always
  // 0, and the run length is at least 1.
  assign cond_field = s1_field[FLD-1] ? ~s1_field : s1_field;
  assign run_len    = lead_zero_count(cond_field);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s2_load;
    end
  end

  // The lead bit and the one bit after it always belong to the regime, so
  // only the bits below them are carried forward for extraction.
  always_ff @(posedge clk) begin
    if (s2_load) begin
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_nar  <= s1_nar;
      s2_lead <= s1_field[FLD-1];
      s2_r    <= run_len;
      s2_tail <= s1_field[TW-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: exponent / fraction extraction and output registers
  // -------------------------------------------------------------------------
  logic                 sign_next;
  logic signed [RS:0]   k_next;
  logic [ES-1:0]        exp_next;
  logic [FW-1:0]        frac_next;
  logic [TW-1:0]        aligned;
  logic [RS-1:0]        tail_shift;

  // The full field would need a shift of r+1. Two of those bits were already
  // dropped in stage 2, so the tail shifts by r-1. Bits that fall off the end
  // after a long or saturated regime read as zero.
  assign tail_shift = s2_r - 1'b1;
  assign aligned    = s2_tail << tail_shift;

  // NOTE: every output of this combinational block gets a default first, so
  // no path can leave a value unassigned and infer a latch.
  always_comb begin
    sign_next = s2_sign;
    k_next    = s2_lead ? $signed({1'b0, s2_r} - 1'b1) : -$signed({1'b0, s2_r});
    exp_next  = aligned[TW-1 -: ES];
    frac_next = aligned[FW-1:0];
    if (s2_zero || s2_nar) begin
      sign_next = s2_nar;
      k_next    = '0;
      exp_next  = '0;
      frac_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      out_sign <= 1'b0;
      out_zero <= 1'b0;
      out_nar  <= 1'b0;
      out_k    <= '0;
      out_exp  <= '0;
      out_frac <= '0;
    end else begin
      if (s3_ready) begin
        s3_valid <= s3_load;
      end
      // The outputs load only on a stage-3 transfer, so they hold during a
      // stall.
      if (s3_load) begin
        out_sign <= sign_next;
        out_zero <= s2_zero;
        out_nar  <= s2_nar;
        out_k    <= k_next;
        out_exp  <= exp_next;
        out_frac <= frac_next;
      end
    end
  end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_posit_decode_pipe
//   Directed and randomized bench for posit_decode_pipe (N=32, ES=2, RS=5).
//   Each accepted input word is decoded by an arithmetic reference model and
//   queued. Each popped result is compared against the front of that queue.
//   Outputs are sampled on the falling edge, and inputs change just after
//   the rising edge.
// ---------------------------------------------------------------------------
module tb_posit_decode_pipe;

  localparam int N  = 32;
  localparam int ES = 2;
  localparam int RS = 5;
  localparam int FW = N - ES - 3;
  localparam int OW = 3 + (RS + 1) + ES + FW;

  typedef struct {
    logic          sign;
    logic          zero;
    logic          nar;
    int            k;
    logic [ES-1:0] exp;
    logic [FW-1:0] frac;
  } dec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        in_posit;
  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic                out_zero;
  logic                out_nar;
  logic signed [RS:0]  out_k;
  logic [ES-1:0]       out_exp;
  logic [FW-1:0]       out_frac;

  posit_decode_pipe #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_nar   (out_nar),
    .out_k     (out_k),
    .out_exp   (out_exp),
    .out_frac  (out_frac)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            pops   = 0;
  dec_t          exp_q[$];
  logic          hold_pending = 1'b0;
  logic [OW-1:0] hold_snap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference decoder: computes the regime from the bit run and takes the
  // exponent and fraction from the remaining bits, using integer arithmetic.
  function automatic dec_t ref_decode(input logic [N-1:0] p);
    dec_t        d;
    logic [63:0] m;
    logic [63:0] tail;
    logic [63:0] aligned;
    logic        first;
    int          r;
    int          rem_len;
    d.sign = 1'b0; d.zero = 1'b0; d.nar = 1'b0; d.k = 0; d.exp = '0; d.frac = '0;
    if (p == 32'h0000_0000) begin
      d.zero = 1'b1;
      return d;
    end
    if (p == 32'h8000_0000) begin
      d.nar  = 1'b1;
      d.sign = 1'b1;
      return d;
    end
    d.sign = p[N-1];
    m      = p[N-1] ? (64'h1_0000_0000 - {32'h0, p}) : {32'h0, p};
    first  = m[N-2];
    r      = 0;
    while (r < N - 1 && m[N-2-r] == first) r++;
    d.k     = first ? r - 1 : -r;
    rem_len = (N - 1) - r - 1;
    if (rem_len > 0) begin
      tail    = m % (64'd1 << rem_len);
      aligned = tail << ((ES + FW) - rem_len);
    end else begin
      aligned = 64'd0;
    end
    d.exp  = ES'(aligned >> FW);
    d.frac = FW'(aligned % (64'd1 << FW));
    return d;
  endfunction

  function automatic logic [OW-1:0] pack_out();
    return {out_sign, out_zero, out_nar, out_k, out_exp, out_frac};
  endfunction

  // One clock cycle: drive the inputs, sample the handshake on the falling
  // edge, check stall stability and popped results, then step past the
  // rising edge.
  task automatic cycle(input logic v, input logic [N-1:0] w, input logic rdy,
                       output logic pushed, output logic rdy_seen);
    dec_t          e;
    logic [OW-1:0] now;
    in_valid  = v;
    in_posit  = w;
    out_ready = rdy;
    @(negedge clk);
    rdy_seen = in_ready;
    pushed   = in_valid && in_ready;
    now      = pack_out();
    if (hold_pending) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(now), 64'(hold_snap));
    end
    hold_pending = out_valid && !out_ready;
    hold_snap    = now;
    if (out_valid && out_ready) begin
      pops++;
      check("model_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sign", 64'(out_sign), 64'(e.sign));
        check("zero", 64'(out_zero), 64'(e.zero));
        check("nar",  64'(out_nar),  64'(e.nar));
        check("k",    64'(out_k),    64'(e.k));
        check("exp",  64'(out_exp),  64'(e.exp));
        check("frac", 64'(out_frac), 64'(e.frac));
      end
    end
    if (pushed) exp_q.push_back(ref_decode(w));
    @(posedge clk);
    #1;
  endtask

  // Push one word into an empty pipeline, wait for the result with
  // out_ready low, compare it against hand-derived constants, then pop it.
  task automatic directed(input string tag, input logic [N-1:0] w,
                          input logic s, input logic z, input logic n,
                          input int k, input logic [ES-1:0] e, input logic [FW-1:0] f);
    logic p, r;
    int   waited;
    cycle(1'b1, w, 1'b0, p, r);
    check({tag, "_accept"}, 64'(p), 64'd1);
    waited = 0;
    while (!out_valid && waited < 8) begin
      cycle(1'b0, '0, 1'b0, p, r);
      waited++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sign"},  64'(out_sign),  64'(s));
    check({tag, "_zero"},  64'(out_zero),  64'(z));
    check({tag, "_nar"},   64'(out_nar),   64'(n));
    check({tag, "_k"},     64'(out_k),     64'(k));
    check({tag, "_exp"},   64'(out_exp),   64'(e));
    check({tag, "_frac"},  64'(out_frac),  64'(f));
    cycle(1'b0, '0, 1'b1, p, r);
  endtask

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    case ($urandom_range(0, 7))
      0:       w = 32'h0000_0000;
      1:       w = 32'h8000_0000;
      2:       w = 32'($urandom_range(0, 255));
      3:       w = ~32'($urandom_range(0, 255));
      4:       w = 32'h7FFF_FFFF >> $urandom_range(0, 31);
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         p, r;
    logic [N-1:0] vec[8];
    logic [N-1:0] bp_words[8];
    int           base, idx, cyc, pushed_n;

    rst = 1'b1; in_valid = 1'b0; in_posit = '0; out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(pack_out()), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: with out_ready high, the result appears three edges after the
    // cycle in which the word is accepted.
    cycle(1'b1, 32'h4000_0000, 1'b1, p, r);
    check("lat_accept", 64'(p), 64'd1);
    check("lat_edge1", 64'(out_valid), 64'd0);
    cycle(1'b0, '0, 1'b1, p, r);
    check("lat_edge2", 64'(out_valid), 64'd0);
    cycle(1'b0, '0, 1'b1, p, r);
    check("lat_edge3", 64'(out_valid), 64'd1);
    cycle(1'b0, '0, 1'b1, p, r);

    // Special values, ordinary values and regime extremes
    directed("zero",   32'h0000_0000, 1'b0, 1'b1, 1'b0,   0, 2'd0, 27'h0);
    directed("nar",    32'h8000_0000, 1'b1, 1'b0, 1'b1,   0, 2'd0, 27'h0);
    directed("one",    32'h4000_0000, 1'b0, 1'b0, 1'b0,   0, 2'd0, 27'h0);
    directed("exp1",   32'h4800_0000, 1'b0, 1'b0, 1'b0,   0, 2'd1, 27'h0);
    directed("frac",   32'h4080_0000, 1'b0, 1'b0, 1'b0,   0, 2'd0, 27'h080_0000);
    directed("neg1",   32'hC000_0000, 1'b1, 1'b0, 1'b0,   0, 2'd0, 27'h0);
    directed("maxpos", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0,  30, 2'd0, 27'h0);
    directed("minpos", 32'h0000_0001, 1'b0, 1'b0, 1'b0, -30, 2'd0, 27'h0);

    // Back-to-back stream at one word per cycle
    vec[0] = 32'h0000_0000; vec[1] = 32'h8000_0000; vec[2] = 32'h4800_0000;
    vec[3] = 32'h4080_0000; vec[4] = 32'hC000_0000; vec[5] = 32'h7FFF_FFFF;
    vec[6] = 32'h0000_0001; vec[7] = 32'h5A5A_A5A5;
    base = pops;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vec[i], 1'b1, p, r);
      check("tput_accept", 64'(p), 64'd1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, p, r);
    check("tput_count", 64'(pops - base), 64'd8);

    // Backpressure: out_ready low for stream cycles 4..9
    for (int i = 0; i < 8; i++) bp_words[i] = $urandom;
    base = pops; idx = 0; cyc = 0;
    while ((idx < 8 || exp_q.size() != 0) && cyc < 60) begin
      cycle(idx < 8, bp_words[idx < 8 ? idx : 0], !(cyc >= 4 && cyc <= 9), p, r);
      if (cyc >= 4 && cyc <= 9) check("bp_in_ready_low", 64'(r), 64'd0);
      if (p) idx++;
      if (cyc == 4) check("bp_buffered", 64'(idx - (pops - base)), 64'd3);
      cyc++;
    end
    check("bp_done", 64'(cyc < 60), 64'd1);
    check("bp_count", 64'(pops - base), 64'd8);

    // Reset with three words in flight
    cycle(1'b1, 32'h6ABC_DEF1, 1'b0, p, r);
    check("mid_push0", 64'(p), 64'd1);
    cycle(1'b1, 32'h1234_5678, 1'b0, p, r);
    check("mid_push1", 64'(p), 64'd1);
    cycle(1'b1, 32'hF0F0_0F0F, 1'b0, p, r);
    check("mid_push2", 64'(p), 64'd1);
    check("mid_full", 64'(out_valid), 64'd1);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    hold_pending = 1'b0;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_out_data", 64'(pack_out()), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd1);
    base = pops;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, p, r);
    check("mid_no_ghost", 64'(pops - base), 64'd0);

    // Random stream with random backpressure
    base = pops; pushed_n = 0; cyc = 0;
    while ((pushed_n < 10000 || exp_q.size() != 0) && cyc < 40000) begin
      cycle(pushed_n < 10000 && ($urandom_range(0, 9) < 8), rand_word(),
            $urandom_range(0, 9) < 7, p, r);
      if (p) pushed_n++;
      cyc++;
    end
    check("rand_done", 64'(cyc < 40000), 64'd1);
    check("rand_count", 64'(pops - base), 64'd10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
